arb_req_queue: RTL and testbench
================================

Name: arb_req_queue

Overview:
- Requester-side front end for the 4-way round-robin arbiter.
- Each client pushes transactions into its own small FIFO. The block raises req_o[i] while FIFO i holds data, and consumes the arbiter's one-hot grant.
- On each grant it pops the granted entry and forwards it, tagged with its source index, on a single shared output.
- It also checks the grant protocol and latches any violation.

Parameters:
- NUM_REQ, 4, number of clients (matches the arbiter request width).
- DATA_W, 8, payload width per transaction.
- DEPTH, 4, entries per client FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; the block resets on the rising clk edge when reset = 0.
- push_i  in  NUM_REQ  per-client write strobe.
- push_data_i  in  NUM_REQ*DATA_W  per-client payload; client i occupies bits [i*DATA_W +: DATA_W].
- full_o  out  NUM_REQ  FIFO i full (count == DEPTH).
- req_o  out  NUM_REQ  request to arbiter; req_o[i] = FIFO i not empty.
- gnt_i  in  NUM_REQ  grant from arbiter; zero or one-hot.
- out_valid_o  out  1  forwarded transaction valid, one-cycle pulse per grant.
- out_data_o  out  DATA_W  forwarded payload.
- out_src_o  out  $clog2(NUM_REQ)  index of the client the payload came from.
- err_o  out  1  sticky grant-protocol error.

Behaviour:
- Reset (reset = 0 at a clk edge): all FIFOs emptied (count, read and write pointers = 0), req_o = 0, full_o = 0, out_valid_o = 0, out_data_o = 0, out_src_o = 0, err_o = 0.
  - Asserting reset mid-operation discards all queued entries and any output due next cycle.
- req_o and full_o are decoded combinationally from registered counts only; there is no combinational path from push_i or gnt_i.
- Push: if push_i[i] = 1 and FIFO i is not full, the payload is written at the write pointer and count increments.
  - Push to a full FIFO is dropped silently; contents and count are unchanged, and err_o is not set.
- Valid grant, defined as gnt_i one-hot with gnt_i[k] = 1 and req_o[k] = 1 in the same cycle:
  - FIFO k pops its head.
  - Next cycle: out_valid_o = 1, out_data_o = popped entry, out_src_o = k. Latency from grant to output is 1 cycle.
- No grant (gnt_i = 0): no pop; out_valid_o = 0 next cycle; out_data_o and out_src_o hold their previous values.
- Protocol error, defined as gnt_i with more than one bit set, or gnt_i[k] = 1 while req_o[k] = 0:
  - No pop occurs, out_valid_o = 0 next cycle, and err_o = 1 from the next cycle until reset.
- Simultaneous push and pop on the same FIFO:
  - Both take effect and count is unchanged.
  - On a full FIFO the pop frees a slot, so the push is accepted.
  - On an empty FIFO req_o was 0, so any grant is a protocol error; the push is still accepted and count becomes 1.
- Wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally. Count is log2(DEPTH)+1 bits wide and ranges 0..DEPTH.
- Back-to-back grants to the same client are allowed. The output pulses on consecutive cycles with consecutive FIFO entries in FIFO order.
- Clients are independent; pushes to several clients in the same cycle are all accepted, subject to each FIFO's full state.

Decomposition:
- Package arb_req_pkg:
  - NUM_REQ and DATA_W defaults.
  - SRC_W = $clog2(NUM_REQ).
  - typedef of the payload (logic [DATA_W-1:0]) and of the source index.
  - Helper function onehot0(), returning 1 when its argument is zero or one-hot.
- Sub-module req_fifo: single-client synchronous FIFO with ports push, pop, wdata, rdata (head), count, empty, full. It is instantiated NUM_REQ times via generate.
- The top level holds the grant checker, pop steering, output register and err_o.

Test Plan:
- Reset/idle: hold reset = 0 for 2 cycles, then release → all outputs 0; req_o = 4'b0000.
- Single transfer: push client 2 with 8'hA5; assert gnt_i = 4'b0100 in the cycle req_o = 4'b0100 → next cycle out_valid_o = 1, out_data_o = 8'hA5, out_src_o = 2; afterwards req_o = 4'b0000.
- Fill, overflow, drain: push client 0 with 8'h01..8'h05 → full_o[0] = 1 after the 4th push and 8'h05 is dropped; 4 grants to client 0 → outputs 8'h01, 8'h02, 8'h03, 8'h04 in order, then req_o[0] = 0.
- Full push+pop: with client 1 full, push 8'h77 and grant client 1 in the same cycle → head is output, count stays 4, and 8'h77 appears as the 4th subsequent output.
- Protocol errors:
  - Case 1: gnt_i = 4'b0011 with both requesting → no pop, out_valid_o = 0, err_o = 1 and stays 1.
  - Case 2: after reset, gnt_i = 4'b1000 with req_o[3] = 0 → err_o = 1.
- All-clients round-robin: preload each client with 2 entries; drive grants 0,1,2,3,0,1,2,3 → out_src_o follows that sequence, each output matches its client's FIFO order, and req_o = 0 at the end.

Source files
------------

// File: rtl/arb_req_pkg.sv
// Shared defaults, types and helpers for the arbiter request queue.
package arb_req_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int SRC_W       = $clog2(DEF_NUM_REQ);

  typedef logic [DEF_DATA_W-1:0] payload_t;
  typedef logic [SRC_W-1:0]      src_t;

  // True when v has no bits set or exactly one bit set.
  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == '0;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Single-client synchronous FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_queue.sv
// Requester front end for the round-robin arbiter: per-client FIFOs, grant check,
// pop steering and a registered shared output tagged with the source index.
module arb_req_queue
  import arb_req_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          push_i,
  input  logic [NUM_REQ*DATA_W-1:0]   push_data_i,
  output logic [NUM_REQ-1:0]          full_o,
  output logic [NUM_REQ-1:0]          req_o,
  input  logic [NUM_REQ-1:0]          gnt_i,
  output logic                        out_valid_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [$clog2(NUM_REQ)-1:0]  out_src_o,
  output logic                        err_o
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] pop;
  logic [CW-1:0]      count [NUM_REQ];
  logic [DATA_W-1:0]  rdata [NUM_REQ];
  logic               grant_ok;
  logic               grant_bad;
  logic [DATA_W-1:0]  sel_data;
  logic [SW-1:0]      sel_src;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_i[g]),
      .pop   (pop[g]),
      .wdata (push_data_i[g*DATA_W +: DATA_W]),
      .rdata (rdata[g]),
      .count (count[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  always_comb begin
    req_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_o[i] = (count[i] != '0);
    end
  end

  assign full_o = full;

  // A grant is honoured only if it is one-hot and lands on a non-empty FIFO.
  assign grant_ok  = (gnt_i != '0) && onehot0(32'(gnt_i)) && ((gnt_i & empty) == '0);
  assign grant_bad = (gnt_i != '0) && !grant_ok;
  assign pop       = grant_ok ? gnt_i : '0;

  always_comb begin
    sel_data = '0;
    sel_src  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_i[i]) begin
        sel_data = rdata[i];
        sel_src  = SW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      out_valid_o <= grant_ok;
      if (grant_ok) begin
        out_data_o <= sel_data;
        out_src_o  <= sel_src;
      end
      if (grant_bad) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// Self-checking bench for arb_req_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_arb_req_queue;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   push_i;
  logic [NR*DW-1:0] push_data_i;
  logic [NR-1:0]   full_o;
  logic [NR-1:0]   req_o;
  logic [NR-1:0]   gnt_i;
  logic            out_valid_o;
  logic [DW-1:0]   out_data_o;
  logic [1:0]      out_src_o;
  logic            err_o;

  always #5 clk = ~clk;

  arb_req_queue #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .full_o      (full_o),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_src_o   (out_src_o),
    .err_o       (err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] mq [NR][$];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;
  logic          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NR-1:0] e_req;
    logic [NR-1:0] e_full;
    for (int i = 0; i < NR; i++) begin
      e_req[i]  = (mq[i].size() != 0);
      e_full[i] = (mq[i].size() == DEPTH);
    end
    chk("req", 32'(req_o), 32'(e_req));
    chk("full", 32'(full_o), 32'(e_full));
    chk("valid", 32'(out_valid_o), 32'(m_valid));
    chk("data", 32'(out_data_o), 32'(m_data));
    chk("src", 32'(out_src_o), 32'(m_src));
    chk("err", 32'(err_o), 32'(m_err));
  endtask

  // Drive one cycle of inputs (called at negedge), advance the model, check after the edge.
  task automatic step(input logic rst, input logic [NR-1:0] psh,
                      input logic [31:0] pd, input logic [NR-1:0] gnt);
    logic ok;
    int   k;
    reset       = rst;
    push_i      = psh;
    push_data_i = pd;
    gnt_i       = gnt;
    ok = 1'b0;
    k  = 0;
    if (!rst) begin
      for (int i = 0; i < NR; i++) mq[i].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = '0;
      m_err   = 1'b0;
    end else begin
      if ($countones(gnt) == 1) begin
        for (int i = 0; i < NR; i++) if (gnt[i]) k = i;
        ok = (mq[k].size() != 0);
      end
      if (gnt != '0 && !ok) m_err = 1'b1;
      m_valid = ok;
      if (ok) begin
        m_data = mq[k].pop_front();
        m_src  = 2'(k);
      end
      for (int i = 0; i < NR; i++) begin
        if (psh[i] && mq[i].size() < DEPTH) mq[i].push_back(pd[i*DW +: DW]);
      end
    end
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, '0, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
  endtask

  initial begin
    reset = 1'b0;
    push_i = '0;
    push_data_i = '0;
    gnt_i = '0;
    @(negedge clk);

    // Reset / idle
    do_reset();
    idle();
    chk("rst_req", 32'(req_o), 32'h0);
    chk("rst_out", {out_valid_o, out_data_o, out_src_o, err_o}, 32'h0);

    // Single transfer on client 2
    step(1'b1, 4'b0100, 32'h00A5_0000, '0);
    chk("t1_req", 32'(req_o), 32'h4);
    step(1'b1, '0, '0, 4'b0100);
    chk("t1_valid", 32'(out_valid_o), 32'h1);
    chk("t1_data", 32'(out_data_o), 32'hA5);
    chk("t1_src", 32'(out_src_o), 32'h2);
    idle();
    chk("t1_req_after", 32'(req_o), 32'h0);
    chk("t1_hold", 32'(out_data_o), 32'hA5);

    // Fill, overflow, drain client 0
    for (int v = 1; v <= 5; v++) step(1'b1, 4'b0001, 32'(v), '0);
    chk("fill_full", 32'(full_o), 32'h1);
    for (int v = 1; v <= 4; v++) begin
      step(1'b1, '0, '0, 4'b0001);
      chk("drain_data", 32'(out_data_o), 32'(v));
    end
    idle();
    chk("drain_req", 32'(req_o), 32'h0);

    // Full push+pop on client 1
    for (int v = 0; v < 4; v++) step(1'b1, 4'b0010, 32'((8'h10 + v) << 8), '0);
    step(1'b1, 4'b0010, 32'h0000_7700, 4'b0010);
    chk("pp_head", 32'(out_data_o), 32'h10);
    chk("pp_full", 32'(full_o), 32'h2);
    for (int v = 0; v < 4; v++) step(1'b1, '0, '0, 4'b0010);
    chk("pp_last", 32'(out_data_o), 32'h77);

    // Protocol error: two-hot grant
    do_reset();
    step(1'b1, 4'b0011, 32'h0000_2211, '0);
    step(1'b1, '0, '0, 4'b0011);
    chk("e1_err", 32'(err_o), 32'h1);
    chk("e1_valid", 32'(out_valid_o), 32'h0);
    chk("e1_req", 32'(req_o), 32'h3);
    idle();
    chk("e1_sticky", 32'(err_o), 32'h1);

    // Protocol error: grant to a non-requester
    do_reset();
    step(1'b1, '0, '0, 4'b1000);
    chk("e2_err", 32'(err_o), 32'h1);

    // Round robin over all clients
    do_reset();
    step(1'b1, 4'b1111, 32'h3020_1000, '0);
    step(1'b1, 4'b1111, 32'h3121_1101, '0);
    for (int r = 0; r < 8; r++) begin
      step(1'b1, '0, '0, 4'(1 << (r % 4)));
      chk("rr_src", 32'(out_src_o), 32'(r % 4));
      chk("rr_data", 32'(out_data_o), 32'(((r % 4) << 4) | (r / 4)));
    end
    chk("rr_req", 32'(req_o), 32'h0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic          rst;
      logic [NR-1:0] psh;
      logic [NR-1:0] gnt;
      int            sel;
      int            cand [$];
      rst = ($urandom_range(0, 79) != 0);
      psh = 4'($urandom);
      sel = $urandom_range(0, 19);
      gnt = '0;
      cand.delete();
      for (int i = 0; i < NR; i++) if (mq[i].size() != 0) cand.push_back(i);
      if (sel == 19) begin
        gnt = 4'($urandom);
      end else if (sel >= 6 && cand.size() != 0) begin
        gnt = 4'(1 << cand[$urandom_range(0, cand.size() - 1)]);
      end
      step(rst, psh, $urandom, gnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
